// File: rtl/cpu_control.sv
// Fetch/decode and PC sequencing for the 8-bit processor: drives ALU controls and
// register-file addresses, and advances the PC unless instruction memory is busy.
module cpu_control #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTRUCTION,
  input  logic            I_BUSYWAIT,
  input  logic            ZERO,
  output logic [PC_W-1:0] PC,
  output logic            I_READ,
  output logic [2:0]      ALUOP,
  output logic            IMM_SEL,
  output logic            NEG_SEL,
  output logic            WRITEENABLE,
  output logic [2:0]      WRITEREG,
  output logic [2:0]      READREG1,
  output logic [2:0]      READREG2,
  output logic [7:0]      IMMEDIATE
);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  state_t          state;
  logic [7:0]      opcode;
  logic            fetch_ok;
  logic [PC_W-1:0] pc4, target, offset, next_pc;
  logic            unused_fields;

  assign opcode        = INSTRUCTION[31:24];
  assign WRITEREG      = INSTRUCTION[18:16];
  assign READREG1      = INSTRUCTION[10:8];
  assign READREG2      = INSTRUCTION[2:0];
  assign IMMEDIATE     = INSTRUCTION[7:0];
  assign unused_fields = ^{INSTRUCTION[15:11]};

  // An instruction commits only on an edge where memory is ready and we are past boot.
  assign fetch_ok = (state != BOOT) && !I_BUSYWAIT;

  always_comb begin
    ALUOP       = 3'b000;
    IMM_SEL     = 1'b0;
    NEG_SEL     = 1'b0;
    WRITEENABLE = 1'b0;
    if (fetch_ok) begin
      case (opcode)
        OP_LOADI: begin IMM_SEL = 1'b1; WRITEENABLE = 1'b1; end
        OP_MOV:   WRITEENABLE = 1'b1;
        OP_ADD:   begin ALUOP = 3'b001; WRITEENABLE = 1'b1; end
        OP_SUB:   begin ALUOP = 3'b001; NEG_SEL = 1'b1; WRITEENABLE = 1'b1; end
        OP_AND:   begin ALUOP = 3'b010; WRITEENABLE = 1'b1; end
        OP_OR:    begin ALUOP = 3'b011; WRITEENABLE = 1'b1; end
        OP_BEQ:   begin ALUOP = 3'b001; NEG_SEL = 1'b1; end
        default:  ;
      endcase
    end
  end

  // Branch offset is a signed word count relative to the following instruction.
  assign offset = {{(PC_W-10){INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  assign pc4    = PC + PC_W'(4);
  assign target = pc4 + offset;

  always_comb begin
    next_pc = pc4;
    if (opcode == OP_J || (opcode == OP_BEQ && ZERO))
      next_pc = target;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= BOOT;
      PC     <= RESET_PC;
      I_READ <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= RUN;
          I_READ <= 1'b1;
        end
        RUN, STALL: begin
          I_READ <= 1'b1;
          if (I_BUSYWAIT) begin
            state <= STALL;
          end else begin
            state <= RUN;
            PC    <= next_pc;
          end
        end
        default: begin
          state  <= BOOT;
          I_READ <= 1'b0;
        end
      endcase
    end
  end

endmodule
